// File: rtl/secuenciador_de_instrucciones.sv
// rtl/secuenciador_de_instrucciones.sv - instruction sequencer FSM for an 8-bit accumulator core
//
// Sequences fetch, IR load, decode, execute, store and halt for a tiny 8-opcode
// machine. A per-request wait counter turns a bus that never acknowledges into
// a sticky ERROR state.
//
// Ports:
//   i_Timming                    system clock, rising edge
//   i_Rst                        asynchronous active-low reset
//   i_Instruccion[2:0]           opcode from the instruction register
//   i_Direccionamiento_inmediato immediate / jump / store address from the IR
//   i_Zero                       ALU zero flag (used by JZ)
//   i_Mem_Ack                    memory acknowledge for the current request
//   i_Pausa                      holds off new fetch requests while high
//   i_Continuar                  restarts execution from HALT
//   o_PC[7:0]                    program counter
//   o_Direccion[7:0]             memory address (PC in FETCH, immediate in MEM_WR, else 0)
//   o_Mem_Req / o_Escribe_Mem    memory request and its write qualifier
//   o_Carga_IR                   instruction register load enable
//   o_ALU_Op[1:0]                00 add, 01 sub
//   o_Sel_Inmediato              register write source is the immediate
//   o_Escribe_Reg                register write enable
//   o_Halt / o_Error             halted / sticky bus timeout
//   o_Estado[2:0]                current state encoding

module secuenciador_de_instrucciones (
    input  logic       i_Timming,
    input  logic       i_Rst,
    input  logic [2:0] i_Instruccion,
    input  logic [7:0] i_Direccionamiento_inmediato,
    input  logic       i_Zero,
    input  logic       i_Mem_Ack,
    input  logic       i_Pausa,
    input  logic       i_Continuar,
    output logic [7:0] o_PC,
    output logic [7:0] o_Direccion,
    output logic       o_Mem_Req,
    output logic       o_Escribe_Mem,
    output logic       o_Carga_IR,
    output logic [1:0] o_ALU_Op,
    output logic       o_Sel_Inmediato,
    output logic       o_Escribe_Reg,
    output logic       o_Halt,
    output logic       o_Error,
    output logic [2:0] o_Estado
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'b000,
        S_CARGA   = 3'b001,
        S_DECODE  = 3'b010,
        S_EXECUTE = 3'b011,
        S_MEM_WR  = 3'b100,
        S_HALT    = 3'b101,
        S_ERROR   = 3'b110
    } estado_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LDI   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_JMP   = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_STORE = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    estado_t    estado;
    logic [7:0] pc;
    logic [3:0] wait_cnt;

    always_ff @(posedge i_Timming or negedge i_Rst) begin
        if (!i_Rst) begin
            estado   <= S_FETCH;
            pc       <= 8'h00;
            wait_cnt <= 4'h0;
        end else begin
            case (estado)
                S_FETCH: begin
                    // A paused fetch issues no request, so the timeout does not run.
                    if (!i_Pausa) begin
                        if (i_Mem_Ack) begin
                            estado   <= S_CARGA;
                            wait_cnt <= 4'h0;
                        end else if (wait_cnt == 4'hF) begin
                            estado <= S_ERROR;
                        end else begin
                            wait_cnt <= wait_cnt + 4'h1;
                        end
                    end
                end
                S_CARGA: begin
                    pc     <= pc + 8'h01;
                    estado <= S_DECODE;
                end
                S_DECODE: begin
                    estado <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    // Counter is cleared here so both FETCH and MEM_WR start from zero.
                    wait_cnt <= 4'h0;
                    estado   <= S_FETCH;
                    case (i_Instruccion)
                        OP_JMP:   pc <= i_Direccionamiento_inmediato;
                        OP_JZ:    if (i_Zero) pc <= i_Direccionamiento_inmediato;
                        OP_STORE: estado <= S_MEM_WR;
                        OP_HALT:  estado <= S_HALT;
                        default:  ;
                    endcase
                end
                S_MEM_WR: begin
                    // Ack in the same cycle the counter saturates still completes the store.
                    if (i_Mem_Ack) begin
                        estado   <= S_FETCH;
                        wait_cnt <= 4'h0;
                    end else if (wait_cnt == 4'hF) begin
                        estado <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 4'h1;
                    end
                end
                S_HALT: begin
                    wait_cnt <= 4'h0;
                    if (i_Continuar) estado <= S_FETCH;
                end
                S_ERROR: begin
                    estado <= S_ERROR;
                end
                default: begin
                    estado <= S_ERROR;
                end
            endcase
        end
    end

    // Outputs decode from state; only EXECUTE looks at the opcode. Everything is
    // also gated by reset so strobes drop the instant i_Rst goes low.
    always_comb begin
        o_Direccion     = 8'h00;
        o_Mem_Req       = 1'b0;
        o_Escribe_Mem   = 1'b0;
        o_Carga_IR      = 1'b0;
        o_ALU_Op        = 2'b00;
        o_Sel_Inmediato = 1'b0;
        o_Escribe_Reg   = 1'b0;
        o_Halt          = 1'b0;
        o_Error         = 1'b0;
        if (i_Rst) begin
            case (estado)
                S_FETCH: begin
                    o_Direccion = pc;
                    o_Mem_Req   = ~i_Pausa;
                end
                S_CARGA: begin
                    o_Carga_IR = 1'b1;
                end
                S_EXECUTE: begin
                    case (i_Instruccion)
                        OP_LDI: begin
                            o_Escribe_Reg   = 1'b1;
                            o_Sel_Inmediato = 1'b1;
                        end
                        OP_ADD: begin
                            o_ALU_Op      = 2'b00;
                            o_Escribe_Reg = 1'b1;
                        end
                        OP_SUB: begin
                            o_ALU_Op      = 2'b01;
                            o_Escribe_Reg = 1'b1;
                        end
                        OP_NOP:  ;
                        default: ;
                    endcase
                end
                S_MEM_WR: begin
                    o_Direccion   = i_Direccionamiento_inmediato;
                    o_Mem_Req     = 1'b1;
                    o_Escribe_Mem = 1'b1;
                end
                S_HALT:  o_Halt  = 1'b1;
                S_ERROR: o_Error = 1'b1;
                default: ;
            endcase
        end
    end

    assign o_PC     = pc;
    assign o_Estado = estado;

endmodule

// File: tb/tb_secuenciador_de_instrucciones.sv
// tb/tb_secuenciador_de_instrucciones.sv - directed self-checking bench for secuenciador_de_instrucciones

module tb_secuenciador_de_instrucciones;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] instr;
    logic [7:0] imm;
    logic       zero, ack, pausa, cont;
    logic [7:0] pc, dir;
    logic       mem_req, esc_mem, carga_ir, sel_inm, esc_reg, halt, err;
    logic [1:0] alu_op;
    logic [2:0] estado;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    secuenciador_de_instrucciones dut (
        .i_Timming                    (clk),
        .i_Rst                        (rst_n),
        .i_Instruccion                (instr),
        .i_Direccionamiento_inmediato (imm),
        .i_Zero                       (zero),
        .i_Mem_Ack                    (ack),
        .i_Pausa                      (pausa),
        .i_Continuar                  (cont),
        .o_PC                         (pc),
        .o_Direccion                  (dir),
        .o_Mem_Req                    (mem_req),
        .o_Escribe_Mem                (esc_mem),
        .o_Carga_IR                   (carga_ir),
        .o_ALU_Op                     (alu_op),
        .o_Sel_Inmediato              (sel_inm),
        .o_Escribe_Reg                (esc_reg),
        .o_Halt                       (halt),
        .o_Error                      (err),
        .o_Estado                     (estado)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one cycle and sample 1 time unit after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; instr = 3'b000; imm = 8'h00; zero = 1'b0;
        ack = 1'b0; pausa = 1'b0; cont = 1'b0;
        #2;
        chk("rst_estado", {5'b0, estado}, 8'h00);
        chk("rst_pc", pc, 8'h00);
        chk("rst_mem_req", {7'b0, mem_req}, 8'h00);
        chk("rst_flags", {6'b0, halt, err}, 8'h00);

        // LDI, all requests acknowledged
        @(negedge clk);
        rst_n = 1'b1; ack = 1'b1; instr = 3'b001; imm = 8'h36;
        #1;
        chk("ldi_fetch_estado", {5'b0, estado}, 8'h00);
        chk("ldi_fetch_req", {7'b0, mem_req}, 8'h01);
        chk("ldi_fetch_dir", dir, 8'h00);
        step();
        chk("ldi_carga_estado", {5'b0, estado}, 8'h01);
        chk("ldi_carga_ir", {7'b0, carga_ir}, 8'h01);
        chk("ldi_carga_req", {7'b0, mem_req}, 8'h00);
        step();
        chk("ldi_decode_estado", {5'b0, estado}, 8'h02);
        chk("ldi_decode_pc", pc, 8'h01);
        chk("ldi_decode_strobes", {6'b0, carga_ir, esc_reg}, 8'h00);
        step();
        chk("ldi_exec_estado", {5'b0, estado}, 8'h03);
        chk("ldi_exec_wr_sel", {6'b0, esc_reg, sel_inm}, 8'h03);
        step();
        chk("ldi_back_estado", {5'b0, estado}, 8'h00);
        chk("ldi_back_pc", pc, 8'h01);

        // JMP 0x40
        instr = 3'b100; imm = 8'h40;
        step(); step(); step();
        chk("jmp_exec_estado", {5'b0, estado}, 8'h03);
        chk("jmp_exec_wr", {7'b0, esc_reg}, 8'h00);
        step();
        chk("jmp_pc", pc, 8'h40);
        chk("jmp_dir", dir, 8'h40);

        // JZ 0x20 not taken, then taken
        instr = 3'b101; imm = 8'h20; zero = 1'b0;
        step(); step(); step(); step();
        chk("jz0_pc", pc, 8'h41);
        zero = 1'b1;
        step(); step(); step(); step();
        chk("jz1_pc", pc, 8'h20);
        zero = 1'b0;

        // SUB
        instr = 3'b011;
        step(); step(); step();
        chk("sub_alu_op", {6'b0, alu_op}, 8'h01);
        chk("sub_wr_sel", {6'b0, esc_reg, sel_inm}, 8'h02);
        step();
        chk("sub_pc", pc, 8'h21);

        // Paused fetch must not time out; ack arriving at count 15 wins
        instr = 3'b000; pausa = 1'b1; ack = 1'b0;
        repeat (20) step();
        chk("pause_estado", {5'b0, estado}, 8'h00);
        chk("pause_req", {7'b0, mem_req}, 8'h00);
        chk("pause_err", {7'b0, err}, 8'h00);
        pausa = 1'b0;
        #1;
        chk("unpause_req", {7'b0, mem_req}, 8'h01);
        repeat (15) step();
        chk("wait15_estado", {5'b0, estado}, 8'h00);
        ack = 1'b1;
        step();
        chk("late_ack_estado", {5'b0, estado}, 8'h01);
        step(); step();
        chk("nop_exec_strobes", {5'b0, esc_reg, mem_req, sel_inm}, 8'h00);
        step();
        chk("nop_pc", pc, 8'h22);

        // STORE with immediate ack
        instr = 3'b110; imm = 8'h55;
        step(); step(); step(); step();
        chk("st_memwr_estado", {5'b0, estado}, 8'h04);
        chk("st_memwr_req_wr", {6'b0, mem_req, esc_mem}, 8'h03);
        chk("st_memwr_dir", dir, 8'h55);
        step();
        chk("st_done_estado", {5'b0, estado}, 8'h00);
        chk("st_done_pc", pc, 8'h23);

        // HALT, frozen for 10 cycles, then continue
        instr = 3'b111;
        step(); step(); step(); step();
        chk("halt_estado", {5'b0, estado}, 8'h05);
        chk("halt_flag", {7'b0, halt}, 8'h01);
        chk("halt_pc", pc, 8'h24);
        repeat (10) step();
        chk("halt10_estado", {5'b0, estado}, 8'h05);
        chk("halt10_pc", pc, 8'h24);
        chk("halt10_req", {7'b0, mem_req}, 8'h00);
        cont = 1'b1;
        step();
        cont = 1'b0;
        chk("cont_estado", {5'b0, estado}, 8'h00);
        chk("cont_halt", {7'b0, halt}, 8'h00);

        // PC wrap: jump to 0xFF, fetch a NOP
        instr = 3'b100; imm = 8'hFF;
        step(); step(); step(); step();
        chk("wrap_pre_pc", pc, 8'hFF);
        instr = 3'b000;
        step(); step();
        chk("wrap_pc", pc, 8'h00);
        step(); step();

        // STORE with ack withheld 16 cycles -> sticky ERROR
        instr = 3'b110; imm = 8'hAA;
        step(); step(); step();
        ack = 1'b0;
        step();
        chk("to_memwr_estado", {5'b0, estado}, 8'h04);
        repeat (15) step();
        chk("to_15_estado", {5'b0, estado}, 8'h04);
        step();
        chk("to_err_estado", {5'b0, estado}, 8'h06);
        chk("to_err_flag", {7'b0, err}, 8'h01);
        chk("to_err_strobes", {5'b0, mem_req, esc_mem, carga_ir}, 8'h00);
        ack = 1'b1;
        repeat (3) step();
        chk("err_sticky", {5'b0, estado}, 8'h06);
        #2 rst_n = 1'b0;
        #1;
        chk("err_rst_estado", {5'b0, estado}, 8'h00);
        chk("err_rst_flag", {7'b0, err}, 8'h00);
        chk("err_rst_pc", pc, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of MEM_WR
        instr = 3'b110; imm = 8'h33;
        #1;
        step(); step(); step();
        ack = 1'b0;
        step();
        chk("ar_memwr_estado", {5'b0, estado}, 8'h04);
        chk("ar_memwr_req", {7'b0, mem_req}, 8'h01);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_estado", {5'b0, estado}, 8'h00);
        chk("ar_pc", pc, 8'h00);
        chk("ar_strobes", {6'b0, mem_req, esc_mem}, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
